stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control and sequencing block for the two-digit BCD stopwatch counter datapath.
- Conditions three raw push-buttons: synchronises, debounces and edge-detects them.
- Runs a run/pause/clear/done state machine and generates the count-enable tick from a clock prescaler.
- Provides a lap-freeze display hold and stops the count at 99.
- Sits between the board buttons and the counter datapath. The datapath's live digits feed back in; the display digits go out to the decoder.

Parameters:
TICK_DIV, 1000, clk cycles per count tick; legal range 2..2^24; prescaler width 24 bits.
DEB_CYCLES, 4, consecutive stable samples needed to accept a button level change; legal range 1..255.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous, active-low reset.
start_stop  input  1  raw button, active-high, asynchronous to clk.
lap  input  1  raw button, active-high, asynchronous.
clear  input  1  raw button, active-high, asynchronous.
msb_in  input  4  live tens digit (BCD) from the counter datapath.
lsb_in  input  4  live units digit (BCD) from the counter datapath.
tick  output  1  one-cycle count-enable pulse to the datapath.
cnt_clr  output  1  one-cycle synchronous clear pulse to the datapath.
disp_msb  output  4  tens digit to display.
disp_lsb  output  4  units digit to display.
running  output  1  high in RUN.
lap_active  output  1  display frozen on the captured lap value.
overflow  output  1  count reached 99; sticky until clear.

Behaviour:
Interface:
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Reset (rst_n=0):
- state=IDLE; prescaler=0; debounce counters=0; lap registers=0.
- All outputs 0.

Button conditioning, per button:
- 2-flop synchroniser feeds a debouncer.
- The debouncer accepts a new level only after DEB_CYCLES consecutive identical synchronised samples.
- A 0->1 transition of the accepted level produces a one-cycle event (ev_ss, ev_lap, ev_clr).
- Latency from a stable raw level to the event: 2+DEB_CYCLES cycles.
- Holding a button produces exactly one event.

Event priority within a cycle: ev_clr > ev_ss > ev_lap. Only the highest-priority event that is legal in the current state acts; lower-priority events in the same cycle are discarded.

FSM states: IDLE, RUN, PAUSE, DONE.

IDLE:
- ev_ss -> RUN; prescaler=0.
- ev_clr -> cnt_clr pulse, stay in IDLE, lap_active=0.
- ev_lap: clears lap_active if it is set, otherwise ignored.

RUN:
- Prescaler increments every cycle.
- At prescaler==TICK_DIV-1:
  - prescaler wraps to 0.
  - If msb_in==9 and lsb_in==9, or either digit >9: no tick, -> DONE, overflow=1.
  - Otherwise tick=1 for that cycle.
- ev_ss -> PAUSE; prescaler value is retained.
- ev_lap toggles lap_active. On 0->1 it captures the current msb_in/lsb_in into the lap registers.
- ev_clr is ignored in RUN.

PAUSE:
- No ticks.
- ev_ss -> RUN; prescaler resumes from its retained value.
- ev_clr -> cnt_clr, prescaler=0, lap_active=0, -> IDLE.
- ev_lap clears lap_active only.

DONE:
- No ticks; overflow=1.
- ev_ss ignored.
- ev_clr -> cnt_clr, overflow=0, lap_active=0, prescaler=0, -> IDLE.
- ev_lap clears lap_active only.

Output timing:
- running is a registered output; it is high in the same cycle the state register is RUN.
- tick and cnt_clr are registered, single-cycle pulses, and are never asserted together.
- tick is never asserted in consecutive cycles (guaranteed by TICK_DIV>=2), so the datapath digits settle before the next comparison.
- disp_msb/disp_lsb are registered with one-cycle latency: lap registers when lap_active=1, otherwise msb_in/lsb_in.

Test Plan:
- Reset mid-RUN: assert rst_n=0 asynchronously -> all outputs 0 immediately without waiting for a clock edge; after release, state IDLE and no tick until a start event.
- TICK_DIV=4, DEB_CYCLES=2: raw start_stop held high -> running=1 exactly 4 cycles after the sync'd edge; then tick pulses every 4 clk cycles.
- Bounce: start_stop toggles every cycle for 10 cycles, then settles high -> exactly one ev_ss; no events during the toggling.
- RUN with datapath at 3/7: lap pressed -> lap_active=1 and disp=3/7 held while ticks continue. Second lap press -> display follows live digits 1 cycle later.
- Datapath at 9/9 at terminal prescale -> no tick, state DONE, overflow=1, running=0. start_stop ignored. clear -> single cnt_clr pulse, overflow=0, IDLE.
- PAUSE at prescaler=2 (TICK_DIV=4) then resume -> first tick after 2 cycles. clear+start_stop in the same cycle from PAUSE -> clear wins: IDLE, cnt_clr=1, running=0.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller, its buttons, the BCD counter datapath and the display.
// master = board/datapath side, slave = stopwatch_ctrl.
interface stopwatch_ctrl_if;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [3:0] msb_in;
  logic [3:0] lsb_in;
  logic       tick;
  logic       cnt_clr;
  logic [3:0] disp_msb;
  logic [3:0] disp_lsb;
  logic       running;
  logic       lap_active;
  logic       overflow;

  modport master (
    output start_stop, lap, clear, msb_in, lsb_in,
    input  tick, cnt_clr, disp_msb, disp_lsb, running, lap_active, overflow
  );

  modport slave (
    input  start_stop, lap, clear, msb_in, lsb_in,
    output tick, cnt_clr, disp_msb, disp_lsb, running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, run/pause/clear/done FSM, tick prescaler,
// lap-freeze display hold and stop-at-99.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned DEB_CYCLES = 4
) (
  input logic             clk,
  input logic             rst_n,
  stopwatch_ctrl_if.slave bus
);

  localparam logic [23:0] PRESC_LAST = 24'(TICK_DIV - 1);
  localparam logic [7:0]  DEB_LAST   = 8'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  // Button index: 0 = start_stop, 1 = lap, 2 = clear
  logic [2:0] btn_raw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] deb_lvl_q, deb_lvl_d;
  logic [2:0] ev_q, ev_d;
  logic [7:0] deb_cnt_q [3];
  logic [7:0] deb_cnt_d [3];

  state_e      state_q, state_d;
  logic [23:0] presc_q, presc_d;
  logic        lap_active_q, lap_active_d;
  logic [3:0]  lap_msb_q, lap_msb_d;
  logic [3:0]  lap_lsb_q, lap_lsb_d;
  logic        overflow_q, overflow_d;
  logic        tick_q, tick_d;
  logic        cnt_clr_q, cnt_clr_d;
  logic        running_q, running_d;
  logic [3:0]  disp_msb_q, disp_msb_d;
  logic [3:0]  disp_lsb_q, disp_lsb_d;

  logic act_clr, act_ss, act_lap;
  logic term_hit, digits_full;

  assign btn_raw = {bus.clear, bus.lap, bus.start_stop};

  // Counter tracks consecutive samples that disagree with the accepted level.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      deb_lvl_d[i] = deb_lvl_q[i];
      ev_d[i]      = 1'b0;
      if (sync2_q[i] == deb_lvl_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_cnt_d[i] = '0;
        deb_lvl_d[i] = sync2_q[i];
        ev_d[i]      = sync2_q[i];
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
      end
    end
  end

  // Only the highest-priority event that is legal in the current state acts.
  assign act_clr     = ev_q[2] && (state_q != RUN);
  assign act_ss      = ev_q[0] && !act_clr && (state_q != DONE);
  assign act_lap     = ev_q[1] && !act_clr && !act_ss;
  assign digits_full = ((bus.msb_in == 4'd9) && (bus.lsb_in == 4'd9)) ||
                       (bus.msb_in > 4'd9) || (bus.lsb_in > 4'd9);
  // A pause on the terminal cycle wins: prescaler holds and no tick is issued.
  assign term_hit    = (state_q == RUN) && !act_ss && (presc_q == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_lvl_q    <= '0;
      ev_q         <= '0;
      deb_cnt_q    <= '{default: '0};
      state_q      <= IDLE;
      presc_q      <= '0;
      lap_active_q <= 1'b0;
      lap_msb_q    <= '0;
      lap_lsb_q    <= '0;
      overflow_q   <= 1'b0;
      tick_q       <= 1'b0;
      cnt_clr_q    <= 1'b0;
      running_q    <= 1'b0;
      disp_msb_q   <= '0;
      disp_lsb_q   <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      deb_lvl_q    <= deb_lvl_d;
      ev_q         <= ev_d;
      deb_cnt_q    <= deb_cnt_d;
      state_q      <= state_d;
      presc_q      <= presc_d;
      lap_active_q <= lap_active_d;
      lap_msb_q    <= lap_msb_d;
      lap_lsb_q    <= lap_lsb_d;
      overflow_q   <= overflow_d;
      tick_q       <= tick_d;
      cnt_clr_q    <= cnt_clr_d;
      running_q    <= running_d;
      disp_msb_q   <= disp_msb_d;
      disp_lsb_q   <= disp_lsb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    unique case (state_q)
      IDLE: begin
        if (act_ss) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      RUN: begin
        if (act_ss) begin
          state_d = PAUSE;
        end else if (term_hit) begin
          presc_d = '0;
          if (digits_full) state_d = DONE;
        end else begin
          presc_d = presc_q + 24'd1;
        end
      end
      PAUSE: begin
        if (act_clr) begin
          state_d = IDLE;
          presc_d = '0;
        end else if (act_ss) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (act_clr) begin
          state_d = IDLE;
          presc_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick_d       = term_hit && !digits_full;
    cnt_clr_d    = act_clr;
    running_d    = (state_d == RUN);
    overflow_d   = overflow_q;
    lap_active_d = lap_active_q;
    lap_msb_d    = lap_msb_q;
    lap_lsb_d    = lap_lsb_q;
    if (term_hit && digits_full) overflow_d = 1'b1;
    if (act_clr) begin
      overflow_d   = 1'b0;
      lap_active_d = 1'b0;
    end else if (act_lap) begin
      if (state_q == RUN) begin
        lap_active_d = !lap_active_q;
        if (!lap_active_q) begin
          lap_msb_d = bus.msb_in;
          lap_lsb_d = bus.lsb_in;
        end
      end else begin
        lap_active_d = 1'b0;
      end
    end
    disp_msb_d = lap_active_q ? lap_msb_q : bus.msb_in;
    disp_lsb_d = lap_active_q ? lap_lsb_q : bus.lsb_in;
  end

  assign bus.tick       = tick_q;
  assign bus.cnt_clr    = cnt_clr_q;
  assign bus.running    = running_q;
  assign bus.lap_active = lap_active_q;
  assign bus.overflow   = overflow_q;
  assign bus.disp_msb   = disp_msb_q;
  assign bus.disp_lsb   = disp_lsb_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus randomized buttons against a cycle-level model
// built from the button/FSM rules; the bench also plays the BCD counter datapath.
module tb_stopwatch_ctrl;
  localparam int unsigned TD = 4;
  localparam int unsigned DB = 2;

  logic clk = 1'b0;
  logic rst_n;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sw_if)
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_e;

  mstate_e     m_st;
  int unsigned m_phase;
  bit          m_lap, m_ovf, m_tick, m_clr, m_run;
  logic [3:0]  m_lm, m_ll, m_dm, m_dl;
  bit          m_acc [3];
  bit          m_ev  [3];
  bit          hist  [3][16];
  logic [3:0]  dp_m, dp_l;
  bit          dp_hold;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [12:0] dut_vec();
    return {sw_if.tick, sw_if.cnt_clr, sw_if.running, sw_if.lap_active, sw_if.overflow,
            sw_if.disp_msb, sw_if.disp_lsb};
  endfunction

  function automatic logic [12:0] model_vec();
    return {m_tick, m_clr, m_run, m_lap, m_ovf, m_dm, m_dl};
  endfunction

  function automatic bit raw_btn(int b);
    case (b)
      0:       return sw_if.start_stop;
      1:       return sw_if.lap;
      default: return sw_if.clear;
    endcase
  endfunction

  task automatic set_btn(int b, bit v);
    case (b)
      0:       sw_if.start_stop = v;
      1:       sw_if.lap = v;
      default: sw_if.clear = v;
    endcase
  endtask

  task automatic set_digits(logic [3:0] m, logic [3:0] l);
    dp_m = m;
    dp_l = l;
    sw_if.msb_in = m;
    sw_if.lsb_in = l;
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_phase = 0;
    m_lap = 0; m_ovf = 0; m_tick = 0; m_clr = 0; m_run = 0;
    m_lm = '0; m_ll = '0; m_dm = '0; m_dl = '0;
    dp_m = '0; dp_l = '0;
    for (int b = 0; b < 3; b++) begin
      m_acc[b] = 0;
      m_ev[b]  = 0;
      for (int k = 0; k < 16; k++) hist[b][k] = 0;
    end
  endtask

  // One clock edge of the reference: FSM consumes last edge's events, then the button
  // filter looks at its window of synchronised samples, then the datapath reacts to last tick.
  task automatic model_edge();
    logic [3:0] m, l;
    bit full, c, s, lp, old_tick, old_clr, eq, v;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m = sw_if.msb_in;
    l = sw_if.lsb_in;
    full = (m == 4'd9 && l == 4'd9) || m > 4'd9 || l > 4'd9;
    old_tick = m_tick;
    old_clr  = m_clr;
    if (m_lap) begin m_dm = m_lm; m_dl = m_ll; end
    else       begin m_dm = m;    m_dl = l;    end
    m_tick = 0;
    m_clr  = 0;
    c  = m_ev[2] && m_st != M_RUN;
    s  = !c && m_ev[0] && m_st != M_DONE;
    lp = !c && !s && m_ev[1];
    case (m_st)
      M_IDLE: begin
        if (c) begin m_clr = 1; m_lap = 0; end
        else if (s) begin m_st = M_RUN; m_phase = 0; end
        else if (lp) m_lap = 0;
      end
      M_RUN: begin
        if (s) m_st = M_PAUSE;
        else if (m_phase == TD - 1) begin
          m_phase = 0;
          if (full) begin m_st = M_DONE; m_ovf = 1; end
          else m_tick = 1;
        end else m_phase++;
        if (lp) begin
          if (!m_lap) begin m_lm = m; m_ll = l; m_lap = 1; end
          else m_lap = 0;
        end
      end
      M_PAUSE: begin
        if (c) begin m_clr = 1; m_phase = 0; m_lap = 0; m_st = M_IDLE; end
        else if (s) m_st = M_RUN;
        else if (lp) m_lap = 0;
      end
      default: begin
        if (c) begin m_clr = 1; m_ovf = 0; m_lap = 0; m_phase = 0; m_st = M_IDLE; end
        else if (lp) m_lap = 0;
      end
    endcase
    m_run = (m_st == M_RUN);
    for (int b = 0; b < 3; b++) begin
      for (int k = 15; k > 0; k--) hist[b][k] = hist[b][k-1];
      hist[b][0] = raw_btn(b);
      v  = hist[b][2];
      eq = 1;
      for (int k = 2; k < DB + 2; k++) if (hist[b][k] != v) eq = 0;
      m_ev[b] = eq && v && !m_acc[b];
      if (eq) m_acc[b] = v;
    end
    if (old_clr) begin
      dp_m = '0; dp_l = '0;
    end else if (old_tick && !dp_hold) begin
      if (dp_l == 4'd9) begin dp_l = '0; dp_m = dp_m + 4'd1; end
      else dp_l = dp_l + 4'd1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    sw_if.msb_in = dp_m;
    sw_if.lsb_in = dp_l;
  endtask

  task automatic press(int b, int hold);
    set_btn(b, 1);
    repeat (hold) step();
    set_btn(b, 0);
    repeat (DB + 4) step();
  endtask

  task automatic test_reset();
    rst_n = 0;
    sw_if.start_stop = 0; sw_if.lap = 0; sw_if.clear = 0;
    dp_hold = 0;
    model_reset();
    set_digits(4'd0, 4'd0);
    repeat (3) step();
    n_checks++;
    if (dut_vec() !== 13'd0) $display("FAIL reset_hold: got %h expected 0", dut_vec());
    else n_pass++;
    rst_n = 1;
    repeat (4) step();
    n_checks++;
    if (dut_vec() !== 13'd0) $display("FAIL reset_idle: got %h expected 0", dut_vec());
    else n_pass++;
  endtask

  task automatic test_start_latency();
    int k;
    set_btn(0, 1);
    k = 0;
    while (!sw_if.running && k < 20) begin step(); k++; end
    n_checks++;
    if (k !== 5) $display("FAIL start_latency: got %0d cycles expected 5", k);
    else n_pass++;
    k = 0;
    while (!sw_if.tick && k < 12) begin step(); k++; end
    n_checks++;
    if (k !== 4) $display("FAIL first_tick: got %0d cycles expected 4", k);
    else n_pass++;
    for (int r = 0; r < 2; r++) begin
      k = 0;
      do begin step(); k++; end while (!sw_if.tick && k < 12);
      n_checks++;
      if (k !== 4) $display("FAIL tick_period: got %0d cycles expected 4", k);
      else n_pass++;
    end
    set_btn(0, 0);
    repeat (DB + 3) step();
    n_checks++;
    if (dut_vec() !== model_vec()) $display("FAIL run_state: got %h expected %h", dut_vec(), model_vec());
    else n_pass++;
  endtask

  task automatic test_bounce();
    int falls, rises, bad;
    bit prev;
    falls = 0; rises = 0; bad = 0;
    prev = sw_if.running;
    for (int i = 0; i < 28; i++) begin
      if (i < 10) set_btn(0, (i % 2) == 0);
      else if (i < 22) set_btn(0, 1);
      else set_btn(0, 0);
      step();
      if (prev && !sw_if.running) falls++;
      if (!prev && sw_if.running) rises++;
      prev = sw_if.running;
      if (dut_vec() !== model_vec()) bad++;
    end
    n_checks++;
    if (falls !== 1 || rises !== 0) $display("FAIL bounce_events: got falls=%0d rises=%0d expected 1/0", falls, rises);
    else n_pass++;
    n_checks++;
    if (bad !== 0) $display("FAIL bounce_model: got %0d mismatching cycles expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_lap();
    int k, ticks, bad;
    logic [3:0] pm, pl;
    dp_hold = 1;
    set_digits(4'd3, 4'd7);
    press(0, 6);
    set_btn(1, 1);
    k = 0;
    while (!sw_if.lap_active && k < 12) begin step(); k++; end
    n_checks++;
    if (sw_if.lap_active !== 1'b1) $display("FAIL lap_on: got %b expected 1", sw_if.lap_active);
    else n_pass++;
    step();
    n_checks++;
    if ({sw_if.disp_msb, sw_if.disp_lsb} !== 8'h37) $display("FAIL lap_capture: got %h expected 37", {sw_if.disp_msb, sw_if.disp_lsb});
    else n_pass++;
    set_btn(1, 0);
    dp_hold = 0;
    ticks = 0; bad = 0;
    repeat (16) begin
      step();
      if (sw_if.tick) ticks++;
      if ({sw_if.disp_msb, sw_if.disp_lsb} !== 8'h37) bad++;
    end
    n_checks++;
    if (ticks !== 4 || bad !== 0) $display("FAIL lap_hold: got ticks=%0d bad_disp=%0d expected 4/0", ticks, bad);
    else n_pass++;
    set_btn(1, 1);
    k = 0;
    while (sw_if.lap_active && k < 12) begin step(); k++; end
    n_checks++;
    if (sw_if.lap_active !== 1'b0) $display("FAIL lap_off: got %b expected 0", sw_if.lap_active);
    else n_pass++;
    pm = sw_if.msb_in;
    pl = sw_if.lsb_in;
    step();
    n_checks++;
    if ({sw_if.disp_msb, sw_if.disp_lsb} !== {pm, pl}) $display("FAIL lap_follow: got %h expected %h", {sw_if.disp_msb, sw_if.disp_lsb}, {pm, pl});
    else n_pass++;
    set_btn(1, 0);
    repeat (DB + 4) step();
  endtask

  task automatic test_overflow();
    int k, ticks, clrs;
    dp_hold = 1;
    set_digits(4'd9, 4'd9);
    ticks = 0; k = 0;
    do begin step(); k++; if (sw_if.tick) ticks++; end while (!sw_if.overflow && k < 10);
    n_checks++;
    if ({sw_if.overflow, sw_if.running, ticks} !== {1'b1, 1'b0, 32'd0})
      $display("FAIL ovf_stop: got ovf=%b run=%b ticks=%0d expected 1/0/0", sw_if.overflow, sw_if.running, ticks);
    else n_pass++;
    press(0, 6);
    n_checks++;
    if ({sw_if.running, sw_if.overflow} !== 2'b01) $display("FAIL done_ignores_ss: got %b expected 01", {sw_if.running, sw_if.overflow});
    else n_pass++;
    set_btn(2, 1);
    clrs = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 6) set_btn(2, 0);
      step();
      if (sw_if.cnt_clr) clrs++;
    end
    n_checks++;
    if (clrs !== 1) $display("FAIL done_clear_pulse: got %0d pulses expected 1", clrs);
    else n_pass++;
    n_checks++;
    if ({sw_if.running, sw_if.overflow, sw_if.lap_active} !== 3'b000) $display("FAIL done_to_idle: got %b expected 000", {sw_if.running, sw_if.overflow, sw_if.lap_active});
    else n_pass++;
    press(0, 6);
    set_digits(4'd1, 4'hC);
    k = 0;
    while (!sw_if.overflow && k < 10) begin step(); k++; end
    n_checks++;
    if ({sw_if.overflow, sw_if.running} !== 2'b10) $display("FAIL ovf_invalid_digit: got %b expected 10", {sw_if.overflow, sw_if.running});
    else n_pass++;
    press(2, 6);
    dp_hold = 0;
  endtask

  task automatic test_pause_resume();
    int k, clrs, rises;
    bit prev;
    set_btn(0, 1);
    k = 0;
    while (!sw_if.running && k < 12) begin step(); k++; end
    set_btn(0, 0);
    k = 0;
    while (!sw_if.tick && k < 8) begin step(); k++; end
    step();
    step();
    set_btn(0, 1);
    k = 0;
    while (sw_if.running && k < 10) begin step(); k++; end
    n_checks++;
    if (sw_if.running !== 1'b0) $display("FAIL pause_entered: got %b expected 0", sw_if.running);
    else n_pass++;
    set_btn(0, 0);
    repeat (DB + 4) step();
    set_btn(0, 1);
    k = 0;
    while (!sw_if.running && k < 12) begin step(); k++; end
    k = 0;
    while (!sw_if.tick && k < 8) begin step(); k++; end
    n_checks++;
    if (k !== 2) $display("FAIL resume_first_tick: got %0d cycles expected 2", k);
    else n_pass++;
    set_btn(0, 0);
    repeat (DB + 4) step();
    press(0, 6);
    sw_if.start_stop = 1;
    sw_if.clear = 1;
    clrs = 0; rises = 0;
    prev = sw_if.running;
    for (int i = 0; i < 14; i++) begin
      if (i == 8) begin sw_if.start_stop = 0; sw_if.clear = 0; end
      step();
      if (sw_if.cnt_clr) clrs++;
      if (!prev && sw_if.running) rises++;
      prev = sw_if.running;
    end
    n_checks++;
    if (clrs !== 1 || rises !== 0 || sw_if.running !== 1'b0)
      $display("FAIL pause_clr_wins: got clr=%0d rises=%0d run=%b expected 1/0/0", clrs, rises, sw_if.running);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int k, bad;
    set_btn(0, 1);
    k = 0;
    while (!sw_if.running && k < 12) begin step(); k++; end
    set_btn(0, 0);
    repeat (7) step();
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if (dut_vec() !== 13'd0) $display("FAIL async_reset: got %h expected 0", dut_vec());
    else n_pass++;
    repeat (2) step();
    rst_n = 1;
    bad = 0;
    repeat (12) begin
      step();
      if (sw_if.tick || sw_if.running) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL post_reset_idle: got %0d active cycles expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 11) == 0) set_btn(b, !raw_btn(b));
      r = $urandom_range(0, 199);
      if (r == 0) set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      else if (r == 1) set_digits(4'd9, 4'd7);
      step();
      n_checks++;
      if (dut_vec() !== model_vec())
        $display("FAIL random_cycle_%0d: got %h expected %h", c, dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_bounce();
    test_lap();
    test_overflow();
    test_pause_resume();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
